// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/control block.
package pipe_hazard_ctrl_pkg;

  // Forwarding select encoding: 0 = register file, k = post-ID slot k
  localparam int unsigned FWD_W = 4;
  localparam logic [FWD_W-1:0] FWD_RF = 4'd0;

  // Slot records hold destinations at a fixed width; narrower addresses are zero-extended
  localparam int unsigned RD_W_MAX = 8;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 8;

  typedef struct packed {
    logic                valid;
    logic                wr_en;
    logic                mem;
    logic [RD_W_MAX-1:0] rd;
  } slot_t;

  // Legal pipeline depth for the slot tracker
  function automatic bit depth_ok(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

  // Lowest forwardable slot must lie inside the tracked slots and past ID/EX
  function automatic bit fwd_min_ok(input int fwd_min, input int depth);
    return (fwd_min >= 2) && (fwd_min <= depth);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority compare of one ID source against all in-flight slots.
module pipe_hazard_ctrl_fwd_select
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH              = 3,
  parameter int REG_ADDRESS_LENGTH = 5,
  parameter int FWD_MIN            = 2,
  parameter bit ZERO_REG           = 1'b1
) (
  input  slot_t [DEPTH-1:0]              slots,
  input  logic                           id_valid,
  input  logic [REG_ADDRESS_LENGTH-1:0]  src,
  input  logic                           src_used,
  output logic [FWD_W-1:0]               fwd_sel,
  output logic                           near_hit
);

  logic [DEPTH-1:0] hit;
  logic             src_live;

  // Per-slot hazard match for this source
  always_comb begin
    src_live = id_valid & src_used & ~(ZERO_REG & (src == '0));
    hit      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit[k] = src_live & slots[k].valid & slots[k].wr_en &
               (slots[k].rd == RD_W_MAX'(src));
    end
  end

  // Youngest forwardable producer wins; hits before FWD_MIN need a stall
  always_comb begin
    fwd_sel  = FWD_RF;
    near_hit = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (k >= FWD_MIN) begin
        if (hit[k-1]) fwd_sel = FWD_W'(k);
      end else begin
        near_hit = near_hit | hit[k-1];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/control: slot tracking, forwarding, stalls, flush and writeback control.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH              = 3,
  parameter int REG_ADDRESS_LENGTH = 5,
  parameter int FWD_MIN            = 2,
  parameter int WAIT_MAX           = 15,
  parameter bit ZERO_REG           = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [REG_ADDRESS_LENGTH-1:0] id_ra,
  input  logic [REG_ADDRESS_LENGTH-1:0] id_rb,
  input  logic                          id_ra_used,
  input  logic                          id_rb_used,
  input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
  input  logic                          id_wr_en,
  input  logic                          id_mem,
  input  logic                          br_taken,
  input  logic                          dmem_ack,
  output logic                          id_stall,
  output logic                          if_flush,
  output logic                          br_commit,
  output logic [DEPTH-1:0]              stage_en,
  output logic [DEPTH-1:0]              stage_valid,
  output logic [3:0]                    fwd_sel_a,
  output logic [3:0]                    fwd_sel_b,
  output logic                          dmem_req,
  output logic                          wb_en,
  output logic [REG_ADDRESS_LENGTH-1:0] wb_addr,
  output logic                          dmem_timeout,
  output logic [31:0]                   stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("pipe_hazard_ctrl: DEPTH must be 2..8");
  end
  if (!fwd_min_ok(FWD_MIN, DEPTH)) begin : g_bad_fwd_min
    $error("pipe_hazard_ctrl: FWD_MIN must be 2..DEPTH");
  end
  if (REG_ADDRESS_LENGTH > int'(RD_W_MAX)) begin : g_bad_aw
    $error("pipe_hazard_ctrl: REG_ADDRESS_LENGTH too wide for slot record");
  end

  slot_t [DEPTH-1:0] slots;
  logic              near_a;
  logic              near_b;
  logic              raw_stall;
  logic              mem_wait;
  logic [WAIT_W-1:0] wait_cnt;

  pipe_hazard_ctrl_fwd_select #(
    .DEPTH              (DEPTH),
    .REG_ADDRESS_LENGTH (REG_ADDRESS_LENGTH),
    .FWD_MIN            (FWD_MIN),
    .ZERO_REG           (ZERO_REG)
  ) u_fwd_a (
    .slots    (slots),
    .id_valid (id_valid),
    .src      (id_ra),
    .src_used (id_ra_used),
    .fwd_sel  (fwd_sel_a),
    .near_hit (near_a)
  );

  pipe_hazard_ctrl_fwd_select #(
    .DEPTH              (DEPTH),
    .REG_ADDRESS_LENGTH (REG_ADDRESS_LENGTH),
    .FWD_MIN            (FWD_MIN),
    .ZERO_REG           (ZERO_REG)
  ) u_fwd_b (
    .slots    (slots),
    .id_valid (id_valid),
    .src      (id_rb),
    .src_used (id_rb_used),
    .fwd_sel  (fwd_sel_b),
    .near_hit (near_b)
  );

  // Stall, flush, enable and writeback decode from slot state and ID inputs
  always_comb begin
    dmem_req    = slots[0].valid & slots[0].mem;
    mem_wait    = dmem_req & ~dmem_ack;
    raw_stall   = near_a | near_b;
    id_stall    = mem_wait | raw_stall;
    br_commit   = br_taken & id_valid & ~id_stall;
    if_flush    = br_commit;
    stage_en    = {DEPTH{~mem_wait}};
    wb_en       = slots[DEPTH-1].valid & slots[DEPTH-1].wr_en & ~mem_wait;
    wb_addr     = slots[DEPTH-1].rd[REG_ADDRESS_LENGTH-1:0];
    stage_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stage_valid[k] = slots[k].valid;
    end
  end

  // Slot shift register: freeze on dmem wait, bubble into slot 1 on RAW stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots <= '0;
    end else if (!mem_wait) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        slots[k] <= slots[k-1];
      end
      if (raw_stall) begin
        slots[0] <= '0;
      end else begin
        slots[0].valid <= id_valid;
        slots[0].wr_en <= id_wr_en;
        slots[0].mem   <= id_mem;
        slots[0].rd    <= RD_W_MAX'(id_rd);
      end
    end
  end

  // Dmem wait counter with sticky timeout; the pipeline keeps waiting after timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt     <= '0;
      dmem_timeout <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt != WAIT_W'(WAIT_MAX)) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt >= WAIT_W'(WAIT_MAX - 1)) dmem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Saturating count of cycles with ID held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (id_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus wait/reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int NV    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid, id_ra_used, id_rb_used, id_wr_en, id_mem, br_taken, dmem_ack;
  logic [AW-1:0] id_ra, id_rb, id_rd;

  logic             id_stall, if_flush, br_commit, dmem_req, wb_en, dmem_timeout;
  logic [DEPTH-1:0] stage_en, stage_valid;
  logic [3:0]       fwd_sel_a, fwd_sel_b;
  logic [AW-1:0]    wb_addr;
  logic [31:0]      stall_cnt;

  logic             id_stall_w2, if_flush_w2, br_commit_w2, dmem_req_w2, wb_en_w2, dmem_timeout_w2;
  logic [DEPTH-1:0] stage_en_w2, stage_valid_w2;
  logic [3:0]       fwd_sel_a_w2, fwd_sel_b_w2;
  logic [AW-1:0]    wb_addr_w2;
  logic [31:0]      stall_cnt_w2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_mem(id_mem), .br_taken(br_taken), .dmem_ack(dmem_ack), .id_stall(id_stall),
    .if_flush(if_flush), .br_commit(br_commit), .stage_en(stage_en), .stage_valid(stage_valid),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .dmem_req(dmem_req), .wb_en(wb_en),
    .wb_addr(wb_addr), .dmem_timeout(dmem_timeout), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.WAIT_MAX(2)) dut_w2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_mem(id_mem), .br_taken(br_taken), .dmem_ack(dmem_ack), .id_stall(id_stall_w2),
    .if_flush(if_flush_w2), .br_commit(br_commit_w2), .stage_en(stage_en_w2),
    .stage_valid(stage_valid_w2), .fwd_sel_a(fwd_sel_a_w2), .fwd_sel_b(fwd_sel_b_w2),
    .dmem_req(dmem_req_w2), .wb_en(wb_en_w2), .wb_addr(wb_addr_w2),
    .dmem_timeout(dmem_timeout_w2), .stall_cnt(stall_cnt_w2)
  );

  typedef struct {
    logic          v, rau, rbu, wr, mem, br, ack;
    logic [AW-1:0] ra, rb, rd;
    logic          stall, brc, req, wb;
    logic [2:0]    sv;
    logic [3:0]    fa, fb;
    logic [AW-1:0] wa;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input int v, ra, rb, rau, rbu, rd, wr, mem, br, ack,
                              input int stall, brc, sv, fa, fb, req, wb, wa);
    vec_t t;
    t.v = 1'(v); t.ra = AW'(ra); t.rb = AW'(rb); t.rau = 1'(rau); t.rbu = 1'(rbu);
    t.rd = AW'(rd); t.wr = 1'(wr); t.mem = 1'(mem); t.br = 1'(br); t.ack = 1'(ack);
    t.stall = 1'(stall); t.brc = 1'(brc); t.sv = 3'(sv); t.fa = 4'(fa); t.fb = 4'(fb);
    t.req = 1'(req); t.wb = 1'(wb); t.wa = AW'(wa);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_id(input int v, ra, rb, rau, rbu, rd, wr, mem, br, ack);
    id_valid = 1'(v); id_ra = AW'(ra); id_rb = AW'(rb); id_ra_used = 1'(rau);
    id_rb_used = 1'(rbu); id_rd = AW'(rd); id_wr_en = 1'(wr); id_mem = 1'(mem);
    br_taken = 1'(br); dmem_ack = 1'(ack);
  endtask

  task automatic nop(input int ack);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, ack);
  endtask

  initial begin
    // v, ra, rb, rau, rbu, rd, wr, mem, br, ack | stall, brc, sv, fa, fb, req, wb, wa
    vecs[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0,   0, 0, 3'b000, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0,   1, 0, 3'b001, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0,   0, 0, 3'b010, 2, 0, 0, 0, 0);
    vecs[3]  = mk(1, 5, 6, 1, 1, 0, 1, 0, 0, 0,   0, 0, 3'b101, 0, 0, 0, 1, 3);
    vecs[4]  = mk(1, 0, 4, 1, 1, 7, 1, 0, 0, 0,   0, 0, 3'b011, 0, 2, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 0, 3'b111, 0, 0, 0, 1, 4);
    vecs[6]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,   0, 0, 3'b111, 0, 0, 0, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3'b111, 0, 0, 0, 1, 7);
    vecs[8]  = mk(1, 5, 5, 1, 1, 9, 1, 0, 0, 0,   0, 0, 3'b110, 2, 2, 0, 1, 5);
    vecs[9]  = mk(1, 5, 1, 1, 1, 10, 1, 0, 0, 0,  0, 0, 3'b101, 3, 0, 0, 1, 5);
    vecs[10] = mk(1, 10, 0, 1, 0, 0, 0, 0, 1, 0,  1, 0, 3'b011, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 10, 0, 1, 0, 0, 0, 0, 1, 0,  0, 1, 3'b110, 2, 0, 0, 1, 9);

    // Reset with a live instruction in ID
    set_id(1, 3, 3, 1, 1, 3, 1, 1, 1, 0);
    #2;
    chk("rst stage_valid", 32'(stage_valid), 32'd0);
    chk("rst wb_en", 32'(wb_en), 32'd0);
    chk("rst fwd_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("rst fwd_sel_b", 32'(fwd_sel_b), 32'd0);
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst hold stage_valid", 32'(stage_valid), 32'd0);
    chk("rst stall_cnt", stall_cnt, 32'd0);
    chk("rst dmem_timeout", 32'(dmem_timeout), 32'd0);
    rst = 1'b1;
    nop(0);
    #1;
    chk("post-rst stage_en", 32'(stage_en), 32'b111);

    // Table-driven pipeline sequence
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      set_id(int'(vecs[i].v), int'(vecs[i].ra), int'(vecs[i].rb), int'(vecs[i].rau),
             int'(vecs[i].rbu), int'(vecs[i].rd), int'(vecs[i].wr), int'(vecs[i].mem),
             int'(vecs[i].br), int'(vecs[i].ack));
      #1;
      chk($sformatf("v%0d id_stall", i), 32'(id_stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d br_commit", i), 32'(br_commit), 32'(vecs[i].brc));
      chk($sformatf("v%0d if_flush", i), 32'(if_flush), 32'(vecs[i].brc));
      chk($sformatf("v%0d stage_en", i), 32'(stage_en), 32'b111);
      chk($sformatf("v%0d stage_valid", i), 32'(stage_valid), 32'(vecs[i].sv));
      chk($sformatf("v%0d fwd_sel_a", i), 32'(fwd_sel_a), 32'(vecs[i].fa));
      chk($sformatf("v%0d fwd_sel_b", i), 32'(fwd_sel_b), 32'(vecs[i].fb));
      chk($sformatf("v%0d dmem_req", i), 32'(dmem_req), 32'(vecs[i].req));
      chk($sformatf("v%0d wb_en", i), 32'(wb_en), 32'(vecs[i].wb));
      chk($sformatf("v%0d wb_addr", i), 32'(wb_addr), 32'(vecs[i].wa));
      chk($sformatf("v%0d w2 id_stall", i), 32'(id_stall_w2), 32'(vecs[i].stall));
      chk($sformatf("v%0d w2 stage_valid", i), 32'(stage_valid_w2), 32'(vecs[i].sv));
    end

    // Writer r12, gap, then a load that waits three cycles
    @(negedge clk); set_id(1, 0, 0, 0, 0, 12, 1, 0, 0, 0); #1;
    chk("stall_cnt after table", stall_cnt, 32'd2);
    chk("w0 wb_addr", 32'(wb_addr), 32'd10);
    @(negedge clk); nop(0);
    @(negedge clk); set_id(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); #1;
    chk("load issue dmem_req", 32'(dmem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); nop(0); #1;
      chk($sformatf("wait%0d dmem_req", i), 32'(dmem_req), 32'd1);
      chk($sformatf("wait%0d stage_en", i), 32'(stage_en), 32'd0);
      chk($sformatf("wait%0d id_stall", i), 32'(id_stall), 32'd1);
      chk($sformatf("wait%0d wb_en", i), 32'(wb_en), 32'd0);
      chk($sformatf("wait%0d stage_valid", i), 32'(stage_valid), 32'b101);
      chk($sformatf("wait%0d timeout", i), 32'(dmem_timeout), 32'd0);
      chk($sformatf("wait%0d w2 timeout", i), 32'(dmem_timeout_w2), (i == 2) ? 32'd1 : 32'd0);
    end
    @(negedge clk); nop(1); #1;
    chk("ack dmem_req", 32'(dmem_req), 32'd1);
    chk("ack id_stall", 32'(id_stall), 32'd0);
    chk("ack stage_en", 32'(stage_en), 32'b111);
    chk("ack wb_en", 32'(wb_en), 32'd1);
    chk("ack wb_addr", 32'(wb_addr), 32'd12);
    @(negedge clk); nop(0); #1;
    chk("post-ack dmem_req", 32'(dmem_req), 32'd0);
    chk("post-ack stall_cnt", stall_cnt, 32'd5);
    chk("post-ack timeout", 32'(dmem_timeout), 32'd0);
    chk("post-ack w2 timeout sticky", 32'(dmem_timeout_w2), 32'd1);

    // Reset pulse in the middle of a dmem wait
    set_id(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
    @(negedge clk); nop(0); #1;
    chk("mid-wait dmem_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    set_id(1, 3, 3, 1, 1, 3, 1, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst mid-wait dmem_req", 32'(dmem_req), 32'd0);
    chk("rst mid-wait stall_cnt", stall_cnt, 32'd0);
    chk("rst mid-wait stage_valid", 32'(stage_valid), 32'd0);
    chk("rst mid-wait w2 timeout", 32'(dmem_timeout_w2), 32'd0);
    chk("rst mid-wait wb_en", 32'(wb_en), 32'd0);
    @(negedge clk); rst = 1'b1; nop(0); #1;
    chk("release stage_en", 32'(stage_en), 32'b111);

    // Wait counter must restart from zero after reset
    @(negedge clk); set_id(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
    @(negedge clk); nop(0); #1;
    chk("rewait dmem_req", 32'(dmem_req), 32'd1);
    @(negedge clk); nop(1);
    @(negedge clk); nop(0); #1;
    chk("rewait w2 timeout", 32'(dmem_timeout_w2), 32'd0);
    chk("rewait stall_cnt", stall_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
